bridge_demux: RTL

- Single-outstanding-request system bridge between the CPU M-stage memory port and the peripherals: DM, TC0, TC1, INTGEN.
- Decodes each CPU access address and forwards the request to exactly one device (one-hot).
- Waits for that device's acknowledge and returns its read data, or a bus error, to the CPU.
- Handles the write-dispatch and read-select ends of the memory-mapped bus that the CPU datapath drives.

---
 rtl/bridge_demux.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/bridge_demux.sv
// bridge_demux
// ------------
// Single-outstanding-request bridge between the CPU M-stage memory port and
// four peripherals (DM, TC0, TC1, INTGEN). An access is decoded in IDLE,
// forwarded to exactly one device, and completed by that device's ack
// (RESP) or by a bus error (ERR: bad decode or TIMEOUT WAIT cycles
// without an ack).
//
// Handshake: cpu_req is a level request that is sampled only in IDLE. The CPU
// holds it, with stable attributes, until it sees the one-cycle cpu_ready
// pulse. cpu_err and cpu_rdata are valid with cpu_ready. Towards the device,
// dev_req stays high with stable dev_sel/dev_we/dev_addr/dev_wdata/dev_byteen
// until the clock edge that samples the selected dev_ack bit. Ack bits of
// unselected devices are ignored.
//
// Ports
//   clk, reset          clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata/byteen   CPU access request
//   cpu_busy            high whenever the FSM is not in IDLE
//   cpu_ready/err/rdata completion pulse, error flag, load data
//   dev_sel             one-hot target {INTGEN, TC1, TC0, DM}
//   dev_req/we/addr/wdata/byteen   request to the selected device
//                       (dev_addr is the offset from the device base)
//   dev_ack[3:0]        per-device ack, same order as dev_sel
//   dev_rdata[127:0]    per-device read data, device i at [32i+31:32i]
//   dbg_state           current FSM state (IDLE=0, WAIT=1, RESP=2, ERR=3)
// All outputs are registered.

module bridge_demux #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  input  logic [3:0]   cpu_byteen,
  output logic         cpu_busy,
  output logic         cpu_ready,
  output logic         cpu_err,
  output logic [31:0]  cpu_rdata,
  output logic [3:0]   dev_sel,
  output logic         dev_req,
  output logic         dev_we,
  output logic [31:0]  dev_addr,
  output logic [31:0]  dev_wdata,
  output logic [3:0]   dev_byteen,
  input  logic [3:0]   dev_ack,
  input  logic [127:0] dev_rdata,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // The counter holds the number of completed WAIT cycles; the access
  // expires at the edge that ends WAIT cycle number TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cpu_busy_q, cpu_busy_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic        cpu_err_q, cpu_err_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [3:0]  dev_sel_q, dev_sel_d;
  logic        dev_req_q, dev_req_d;
  logic        dev_we_q, dev_we_d;
  logic [31:0] dev_addr_q, dev_addr_d;
  logic [31:0] dev_wdata_q, dev_wdata_d;
  logic [3:0]  dev_byteen_q, dev_byteen_d;

  // Address decode of the live CPU request (only acted on in IDLE).
  logic        hit_dm, hit_tc0, hit_tc1, hit_int, hit_ctrl;
  logic        dec_err;
  logic [3:0]  dec_sel;
  logic [31:0] dec_base;
  logic [31:0] dec_off;

  always_comb begin
    hit_dm   = (cpu_addr <= 32'h0000_2FFF);
    hit_tc0  = (cpu_addr >= 32'h0000_7F00) && (cpu_addr <= 32'h0000_7F0B);
    hit_tc1  = (cpu_addr >= 32'h0000_7F10) && (cpu_addr <= 32'h0000_7F1B);
    hit_int  = (cpu_addr >= 32'h0000_7F20) && (cpu_addr <= 32'h0000_7F23);
    hit_ctrl = hit_tc0 | hit_tc1 | hit_int;
    dec_sel  = {hit_int, hit_tc1, hit_tc0, hit_dm};

    // Control registers only accept aligned, full-word accesses; a store
    // that enables no byte is meaningless on any device.
    dec_err = ~(hit_dm | hit_ctrl)
            | (hit_ctrl & (cpu_addr[1:0] != 2'b00))
            | (cpu_we & hit_ctrl & (cpu_byteen != 4'b1111))
            | (cpu_we & (cpu_byteen == 4'b0000));

    dec_base = 32'h0000_0000;
    if (hit_tc0) dec_base = 32'h0000_7F00;
    if (hit_tc1) dec_base = 32'h0000_7F10;
    if (hit_int) dec_base = 32'h0000_7F20;
    dec_off = cpu_addr - dec_base;
  end

  // Ack and read data of the selected device only. dev_sel_q is one-hot
  // (or zero), so OR-ing the gated slices is a plain mux.
  logic        ack_sel;
  logic [31:0] sel_rdata;

  always_comb begin
    ack_sel   = |(dev_ack & dev_sel_q);
    sel_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (dev_sel_q[i]) sel_rdata = sel_rdata | dev_rdata[32*i +: 32];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cpu_ready_d  = 1'b0;
    cpu_err_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dev_sel_d    = dev_sel_q;
    dev_req_d    = dev_req_q;
    dev_we_d     = dev_we_q;
    dev_addr_d   = dev_addr_q;
    dev_wdata_d  = dev_wdata_q;
    dev_byteen_d = dev_byteen_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cpu_req) begin
          if (dec_err) begin
            state_d     = S_ERR;
            cpu_ready_d = 1'b1;
            cpu_err_d   = 1'b1;
            cpu_rdata_d = '0;
          end else begin
            state_d      = S_WAIT;
            dev_sel_d    = dec_sel;
            dev_req_d    = 1'b1;
            dev_we_d     = cpu_we;
            dev_addr_d   = dec_off;
            dev_wdata_d  = cpu_wdata;
            dev_byteen_d = cpu_byteen;
          end
        end
      end

      S_WAIT: begin
        // The ack is tested first so it wins over a same-cycle expiry.
        if (ack_sel) begin
          state_d     = S_RESP;
          cpu_ready_d = 1'b1;
          cpu_rdata_d = dev_we_q ? 32'h0 : sel_rdata;
          dev_sel_d   = '0;
          dev_req_d   = 1'b0;
          cnt_d       = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d     = S_ERR;
          cpu_ready_d = 1'b1;
          cpu_err_d   = 1'b1;
          cpu_rdata_d = '0;
          dev_sel_d   = '0;
          dev_req_d   = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_RESP, S_ERR: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: state_d = S_IDLE;
    endcase

    cpu_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cpu_busy_q   <= 1'b0;
      cpu_ready_q  <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dev_sel_q    <= '0;
      dev_req_q    <= 1'b0;
      dev_we_q     <= 1'b0;
      dev_addr_q   <= '0;
      dev_wdata_q  <= '0;
      dev_byteen_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cpu_busy_q   <= cpu_busy_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_err_q    <= cpu_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dev_sel_q    <= dev_sel_d;
      dev_req_q    <= dev_req_d;
      dev_we_q     <= dev_we_d;
      dev_addr_q   <= dev_addr_d;
      dev_wdata_q  <= dev_wdata_d;
      dev_byteen_q <= dev_byteen_d;
    end
  end

  assign cpu_busy   = cpu_busy_q;
  assign cpu_ready  = cpu_ready_q;
  assign cpu_err    = cpu_err_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dev_sel    = dev_sel_q;
  assign dev_req    = dev_req_q;
  assign dev_we     = dev_we_q;
  assign dev_addr   = dev_addr_q;
  assign dev_wdata  = dev_wdata_q;
  assign dev_byteen = dev_byteen_q;
  assign dbg_state  = state_q;

endmodule
